// File: rtl/regfile_nrd.sv
// Architectural register file: one synchronous write port, NUM_RD combinational read ports, hardwired-zero index.
// Latency: reads are zero-cycle (mux tree from storage); writes land on the rising edge. No backpressure.
// REGFILE_BYPASS_EN adds a same-cycle write-through path per read port.
module regfile_nrd #(
   parameter int WIDTH    = 64,
   parameter int ADDR_W   = 5,
   parameter int NUM_RD   = 2,
   parameter int ZERO_IDX = 31
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       RegWrite,
   input  logic [ADDR_W-1:0]          WriteRegister,
   input  logic [WIDTH-1:0]           WriteData,
   input  logic [NUM_RD*ADDR_W-1:0]   ReadRegister,
   output logic [NUM_RD*WIDTH-1:0]    ReadData
);

   localparam int                DEPTH    = 2**ADDR_W;
   localparam bit                HAS_ZERO = (ZERO_IDX < DEPTH);
   localparam logic [ADDR_W-1:0] ZERO_A   = ADDR_W'(ZERO_IDX);

   logic [WIDTH-1:0] regs [DEPTH];
   logic             wr_en;

   assign wr_en = RegWrite && (!HAS_ZERO || (WriteRegister != ZERO_A));

   for (genvar r = 0; r < DEPTH; r++) begin : g_reg
      if (r == ZERO_IDX) begin : g_zero
         assign regs[r] = '0;
      end else begin : g_flop
         logic [WIDTH-1:0] q;
         always_ff @(posedge clk) begin
            if (reset) begin
               q <= '0;
            end else if (wr_en && (WriteRegister == ADDR_W'(r))) begin
               q <= WriteData;
            end
         end
         assign regs[r] = q;
      end
   end

   for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
      logic [ADDR_W-1:0] sel;
      logic [WIDTH-1:0]  tree_q;

      assign sel = ReadRegister[p*ADDR_W +: ADDR_W];

      if (ADDR_W >= 4) begin : g_tree
         localparam int NGRP = DEPTH / 16;
         // Heap-ordered tree: leaves are 16:1 groups, node n picks child by one upper select bit.
         logic [WIDTH-1:0] node [2*NGRP-1];

         for (genvar g = 0; g < NGRP; g++) begin : g_leaf
            localparam logic [ADDR_W-1:0] BASE = ADDR_W'(g * 16);
            assign node[NGRP-1+g] = regs[BASE + ADDR_W'(sel[3:0])];
         end

         for (genvar n = 0; n < NGRP-1; n++) begin : g_node
            localparam int LVL = $clog2(n + 2) - 1;
            assign node[n] = sel[ADDR_W-1-LVL] ? node[2*n+2] : node[2*n+1];
         end

         assign tree_q = node[0];
      end else begin : g_flat
         assign tree_q = regs[sel];
      end

`ifdef REGFILE_BYPASS_EN
      assign ReadData[p*WIDTH +: WIDTH] =
         (wr_en && !reset && (WriteRegister == sel)) ? WriteData : tree_q;
`else
      assign ReadData[p*WIDTH +: WIDTH] = tree_q;
`endif
   end

endmodule

// File: tb/tb_regfile_nrd.sv
// Scoreboard bench for regfile_nrd: default 64x32x2 instance plus a 32-bit, 64-entry, 3-port sweep instance.
module tb_regfile_nrd;

`ifdef REGFILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         reset;

   logic         we1;
   logic [4:0]   wa1;
   logic [63:0]  wd1;
   logic [9:0]   ra1;
   logic [127:0] rd1;

   logic         we2;
   logic [5:0]   wa2;
   logic [31:0]  wd2;
   logic [17:0]  ra2;
   logic [95:0]  rd2;

   always #5 clk = ~clk;

   regfile_nrd #(.WIDTH(64), .ADDR_W(5), .NUM_RD(2), .ZERO_IDX(31)) dut1 (
      .clk(clk), .reset(reset), .RegWrite(we1), .WriteRegister(wa1),
      .WriteData(wd1), .ReadRegister(ra1), .ReadData(rd1)
   );

   regfile_nrd #(.WIDTH(32), .ADDR_W(6), .NUM_RD(3), .ZERO_IDX(63)) dut2 (
      .clk(clk), .reset(reset), .RegWrite(we2), .WriteRegister(wa2),
      .WriteData(wd2), .ReadRegister(ra2), .ReadData(rd2)
   );

   typedef struct {
      int          dut;
      int          port;
      logic [63:0] exp;
      string       tag;
   } exp_t;

   exp_t sbq[$];
   int   nvec = 0;
   int   nerr = 0;

   task automatic push(input int dut, input int port, input logic [63:0] v, input string tag);
      exp_t e;
      e.dut  = dut;
      e.port = port;
      e.exp  = v;
      e.tag  = tag;
      sbq.push_back(e);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Monitor: every pending expectation is compared at the falling edge of the cycle it was issued in.
   exp_t        me;
   logic [63:0] got;
   always @(negedge clk) begin
      while (sbq.size() > 0) begin
         me = sbq.pop_front();
         if (me.dut == 1) got = rd1[me.port*64 +: 64];
         else             got = {32'h0, rd2[me.port*32 +: 32]};
         nvec++;
         if (got !== me.exp) begin
            nerr++;
            $display("FAIL %s dut%0d port%0d: got %h expected %h", me.tag, me.dut, me.port, got, me.exp);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL timeout: bench did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      int          idx;
      logic [31:0] v32;

      reset = 1'b1;
      we1 = 1'b0; wa1 = '0; wd1 = '0; ra1 = '0;
      we2 = 1'b0; wa2 = '0; wd2 = '0; ra2 = '0;
      step();
      step();

      reset = 1'b0;
      ra1 = {5'd0, 5'd5};
      push(1, 0, 64'h0, "rst_init");
      push(1, 1, 64'h0, "rst_init");

      we1 = 1'b1; wa1 = 5'd5; wd1 = 64'hDEAD_BEEF;
      step();
      we1 = 1'b0; ra1 = {5'd5, 5'd5};
      push(1, 0, 64'hDEAD_BEEF, "pre_rst_x5");
      push(1, 1, 64'hDEAD_BEEF, "pre_rst_x5");
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      for (int i = 0; i < 32; i++) begin
         ra1 = {5'(31 - i), 5'(i)};
         push(1, 0, 64'h0, "rst_clear");
         push(1, 1, 64'h0, "rst_clear");
         step();
      end

      we1 = 1'b1; wa1 = 5'd7; wd1 = 64'h0123_4567_89AB_CDEF;
      step();
      we1 = 1'b0; ra1 = {5'd7, 5'd7};
      push(1, 0, 64'h0123_4567_89AB_CDEF, "basic_x7");
      push(1, 1, 64'h0123_4567_89AB_CDEF, "basic_x7");
      step();
      ra1 = {5'd8, 5'd6};
      push(1, 0, 64'h0, "basic_x6");
      push(1, 1, 64'h0, "basic_x8");
      step();

      we1 = 1'b1; wa1 = 5'd31; wd1 = 64'hFFFF_FFFF_FFFF_FFFF; ra1 = {5'd31, 5'd31};
      push(1, 0, 64'h0, "zero_wcyc");
      push(1, 1, 64'h0, "zero_wcyc");
      step();
      we1 = 1'b0;
      push(1, 0, 64'h0, "zero_after");
      push(1, 1, 64'h0, "zero_after");
      step();

      we1 = 1'b1; wa1 = 5'd3; wd1 = 64'h11;
      step();
      wa1 = 5'd4; wd1 = 64'h44;
      step();
      wa1 = 5'd3; wd1 = 64'h22; ra1 = {5'd4, 5'd3};
      push(1, 0, BYP ? 64'h22 : 64'h11, "rdw_before");
      push(1, 1, 64'h44, "rdw_other");
      step();
      we1 = 1'b0;
      push(1, 0, 64'h22, "rdw_after");
      push(1, 1, 64'h44, "rdw_other");
      step();

      we1 = 1'b1; wa1 = 5'd9; wd1 = 64'h99;
      step();
      reset = 1'b1; wa1 = 5'd9; wd1 = 64'h55; ra1 = {5'd7, 5'd9};
      push(1, 0, 64'h99, "coll_pre");
      push(1, 1, 64'h0123_4567_89AB_CDEF, "coll_pre");
      step();
      reset = 1'b0; we1 = 1'b0;
      push(1, 0, 64'h0, "coll_x9");
      push(1, 1, 64'h0, "coll_x7");
      step();

      for (int i = 0; i < 64; i++) begin
         we2 = 1'b1; wa2 = 6'(i); wd2 = 32'hA500_0000 + 32'(i);
         step();
      end
      we2 = 1'b0;
      for (int i = 0; i < 64; i++) begin
         for (int p = 0; p < 3; p++) begin
            idx = (i + p * 21) % 64;
            ra2[p*6 +: 6] = 6'(idx);
            v32 = (idx == 63) ? 32'h0 : 32'hA500_0000 + 32'(idx);
            push(2, p, {32'h0, v32}, "sweep");
         end
         step();
      end

      step();
      step();
      if (sbq.size() != 0) begin
         nerr++;
         $display("FAIL drain: got %0d pending expected 0", sbq.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
